xdemux_rr_arbiter: RTL and testbench
====================================

// Module: xdemux_rr_arbiter
// PURPOSE
//  Round-robin scheduler for the 4-input, 10-bit FIFO-to-destination datapath.
//  - Drives the demux select for the input-FIFO mux.
//  - Pops the granted input FIFO and pushes the destination FIFO selected by word[9:8] (destino).
//  - Grants bursts of up to BURST_MAX words.
//  - Stalls while the target destination FIFO reports almost-full.
//  - Sits between the input FIFO bank, the demux and the output FIFO bank.
// PARAMETERS
//  BURST_MAX  4  max words moved per grant before re-arbitration (1..7)
//  CNT_W      3  burst counter width; must hold BURST_MAX
// PORTS
//  clk               in   1  single clock, rising edge
//  reset             in   1  asynchronous, active-low; outputs forced to reset values while low
//  enable            in   1  1 = scheduling allowed
//  fifo_empty        in   4  empty flags of input FIFOs 0..3
//  destino           in   2  dest field of the currently muxed head word (bits [9:8])
//  dest_almost_full  in   4  almost-full flags of destination FIFOs 0..3
//  demux             out  2  registered select driving the input mux
//  pop               out  4  one-hot pop of the granted input FIFO; all zero when no transfer
//  push              out  4  one-hot push of destination FIFO destino; asserted same cycle as pop
//  active            out  1  1 while in XFER
// BEHAVIOUR
//  Reset values: demux=0, pop=0, push=0, active=0, state=IDLE, burst_cnt=0, last_grant=3.
//  - last_grant=3 at reset means the first grant goes to FIFO 0.
//  Input FIFOs are show-ahead: head word is valid while !empty. A word moves when pop and push are both high in one cycle.
//  pop and push are combinational from registered state/demux and current flags. demux, state and counters are registered.
//  FSM:
//   IDLE: pop=push=0.
//    - Go to ARB when enable && any(!fifo_empty).
//   ARB (1 cycle): demux <= first non-empty index after last_grant, cyclic (last+1, +2, +3, last).
//    - last_grant <= that index; burst_cnt <= 0.
//    - Next state XFER.
//    - If no FIFO is non-empty, or enable=0, return to IDLE instead.
//   XFER: xfer_ok = !fifo_empty[demux] && !dest_almost_full[destino].
//    - If xfer_ok && enable: pop[demux]=1, push[destino]=1, burst_cnt++.
//    - If the FIFO is non-empty but the destination is almost-full: hold; no pop/push; burst_cnt frozen.
//    - Leave XFER (next state ARB if any other request exists, else IDLE) when any of:
//      - the word just moved was word number BURST_MAX;
//      - fifo_empty[demux]=1;
//      - enable=0.
//  Latency: first pop occurs 2 cycles after a request is seen in IDLE (IDLE->ARB->XFER).
//  Boundaries:
//   - Destination stall may last indefinitely; the grant is not revoked, so a slow destination blocks its source.
//   - Source empties mid-burst: no pop that cycle; re-arbitrate.
//   - enable drops mid-XFER: no pop that cycle; go to IDLE; last_grant keeps the granted index.
//   - All 4 requesting continuously: grant order 0,1,2,3,0...
//   - A single requester re-wins after ARB, costing 1 bubble cycle per burst.
//   - reset low mid-burst: immediate return to reset values; the in-flight word is not popped.
//   - destino is only sampled when fifo_empty[demux]=0; an X on an empty head must not cause a push.
//   - pop and push are always one-hot or zero; never two bits set.
// STRUCTURE
//  Shared package/include: state encodings IDLE=2'd0, ARB=2'd1, XFER=2'd2; NUM_FIFOS=4; DEST_W=2.
//  One sub-module: rr_pick4 (combinational).
//   - Inputs: req[3:0], last[1:0].
//   - Outputs: gnt_idx[1:0], any_req.
//  The FSM, burst counter and pop/push decode stay in this module.
// TESTING
//  1. Reset mid-burst: FIFO0 holding 3 words, assert reset low during XFER -> pop=push=0 immediately; demux=0, active=0.
//  2. Single requester: FIFO2 holds 6 words, all dest=1, BURST_MAX=4 -> 4 pops/pushes on push[1], 1 ARB bubble, then 2 more; demux=2 throughout.
//  3. All 4 FIFOs full, dest = own index -> grant order 0,1,2,3,0; each burst exactly 4 words; no cycle with two pop bits.
//  4. Back-pressure: dest_almost_full[3]=1 for 5 cycles during a FIFO1 burst to dest 3 -> pop=push=0 for 5 cycles, burst_cnt frozen; transfer resumes on release.
//  5. Source drains: FIFO0 has 2 words, FIFO3 has 1 -> 2 transfers from 0, ARB, 1 transfer from 3, then IDLE with active=0.
//  6. enable toggled low mid-burst -> no pop that cycle; IDLE next cycle; re-enable -> next grant starts after the previous last_grant.

Source files
------------

// File: rtl/xdemux_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// xdemux_rr_arbiter_pkg
//   Shared definitions for the 4-input FIFO-to-destination round-robin
//   scheduler: FSM state encoding, datapath sizes and a one-hot decode helper.
// -----------------------------------------------------------------------------
package xdemux_rr_arbiter_pkg;

  localparam int NUM_FIFOS = 4;  // input FIFOs and destination FIFOs
  localparam int DEST_W    = 2;  // width of an index / destination field

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_e;

  // Index -> one-hot strobe across the FIFO bank.
  function automatic logic [NUM_FIFOS-1:0] decode_onehot(input logic [DEST_W-1:0] idx);
    logic [NUM_FIFOS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/xdemux_rr_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
//   Combinational round-robin picker over four requesters. Returns the first
//   requesting index after 'last', searching last+1, last+2, last+3, last.
//   Ports:
//     req     in  [3:0]  request vector (1 = FIFO has a word)
//     last    in  [1:0]  index granted most recently
//     gnt_idx out [1:0]  winning index (equals 'last' when nobody requests)
//     any_req out        at least one request present
// -----------------------------------------------------------------------------
module rr_pick4
  import xdemux_rr_arbiter_pkg::*;
(
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [DEST_W-1:0]    last,
  output logic [DEST_W-1:0]    gnt_idx,
  output logic                 any_req
);

  logic [DEST_W-1:0] cand;
  logic              found;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    gnt_idx = last;
    cand    = '0;
    found   = 1'b0;
    // The 2-bit add wraps, so offset 4 lands back on 'last' itself.
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      cand = last + DEST_W'(k);
      if (!found && req[cand]) begin
        gnt_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/xdemux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// xdemux_rr_arbiter
//   Round-robin scheduler between a bank of four show-ahead input FIFOs and
//   four destination FIFOs. It selects one input through the demux select,
//   then moves up to BURST_MAX words from it, pushing each into the
//   destination named by the head word's destino field. A destination that
//   reports almost-full stalls the burst without revoking the grant.
//   Ports:
//     clk              in       rising-edge clock
//     reset            in       asynchronous, active-low reset
//     enable           in       1 = scheduling allowed
//     fifo_empty       in  [3:0] empty flags of input FIFOs
//     destino          in  [1:0] destination field of the muxed head word
//     dest_almost_full in  [3:0] almost-full flags of destination FIFOs
//     demux            out [1:0] registered input-mux select
//     pop              out [3:0] one-hot pop of the granted input FIFO
//     push             out [3:0] one-hot push of destination FIFO destino
//     active           out       high while a burst is in progress (XFER)
// -----------------------------------------------------------------------------
module xdemux_rr_arbiter
  import xdemux_rr_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4,  // words per grant before re-arbitration (1..7)
  parameter int CNT_W     = 3   // must be able to hold BURST_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [DEST_W-1:0]    destino,
  input  logic [NUM_FIFOS-1:0] dest_almost_full,
  output logic [DEST_W-1:0]    demux,
  output logic [NUM_FIFOS-1:0] pop,
  output logic [NUM_FIFOS-1:0] push,
  output logic                 active
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

  state_e            state_q, state_d;
  logic [DEST_W-1:0] demux_q, demux_d;
  logic [DEST_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

  logic [DEST_W-1:0] gnt_idx;
  logic              any_req;
  logic              src_empty;
  logic              xfer_ok;
  logic              move;

  rr_pick4 u_pick (
    .req     (~fifo_empty),
    .last    (last_grant_q),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  // The source-empty term comes first so an unknown destino on an empty head
  // resolves xfer_ok to 0 and can never produce a push.
  assign src_empty = fifo_empty[demux_q];
  assign xfer_ok   = !src_empty && !dest_almost_full[destino];
  assign move      = (state_q == XFER) && xfer_ok && enable;

  always_comb begin
    state_d      = state_q;
    demux_d      = demux_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    pop          = '0;
    push         = '0;

    unique case (state_q)
      IDLE: begin
        if (enable && any_req) state_d = ARB;
      end

      ARB: begin
        if (enable && any_req) begin
          demux_d      = gnt_idx;
          last_grant_d = gnt_idx;
          burst_cnt_d  = '0;
          state_d      = XFER;
        end else begin
          state_d = IDLE;
        end
      end

      XFER: begin
        if (move) begin
          pop         = decode_onehot(demux_q);
          push        = decode_onehot(destino);
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        // A stalled destination keeps the grant; only a finished burst, a
        // drained source or a disable ends it. any_req still sees the current
        // source, so a lone requester re-wins after one ARB cycle.
        if (!enable) begin
          state_d = IDLE;
        end else if (src_empty || (move && burst_cnt_q == BURST_LAST)) begin
          state_d = any_req ? ARB : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      demux_q      <= '0;
      last_grant_q <= DEST_W'(NUM_FIFOS - 1);  // first grant goes to FIFO 0
      burst_cnt_q  <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      state_q      <= state_d;
      demux_q      <= demux_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign demux  = demux_q;
  assign active = (state_q == XFER);

endmodule

// File: tb/tb_xdemux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xdemux_rr_arbiter
//   Self-checking bench. Input FIFOs are modelled as queues of 10-bit words;
//   a transaction-level scheduler model (grant owner, words moved, phase)
//   predicts pop/push/demux/active every cycle. A raw vector table covers the
//   destination back-pressure case; directed sequences cover reset, single
//   requester, full rotation, draining and enable drop; then random traffic.
// -----------------------------------------------------------------------------
module tb_xdemux_rr_arbiter;
  import xdemux_rr_arbiter_pkg::*;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] fifo_empty;
  logic [1:0] destino;
  logic [3:0] dest_almost_full;
  logic [1:0] demux;
  logic [3:0] pop;
  logic [3:0] push;
  logic       active;

  always #5 clk = ~clk;

  xdemux_rr_arbiter #(.BURST_MAX(BURST), .CNT_W(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .fifo_empty       (fifo_empty),
    .destino          (destino),
    .dest_almost_full (dest_almost_full),
    .demux            (demux),
    .pop              (pop),
    .push             (push),
    .active           (active)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- environment + reference model ----------------
  logic [9:0] q[4][$];
  logic       en_drv;
  logic [3:0] daf_drv;
  int         pop_log[$];
  int         pop_cyc[$];
  int         push1_cnt;
  int         cyc;

  // Model: phase 0 = waiting for work, 1 = choosing, 2 = moving words.
  int m_phase, m_sel, m_last, m_moved;

  task automatic model_reset();
    m_phase = 0;
    m_sel   = 0;
    m_last  = 3;
    m_moved = 0;
  endtask

  task automatic cycle();
    logic [3:0] emp;
    logic [3:0] e_pop, e_push;
    bit         any, moving, was_empty;
    int         pick;
    for (int i = 0; i < 4; i++) emp[i] = (q[i].size() == 0);
    fifo_empty       = emp;
    enable           = en_drv;
    dest_almost_full = daf_drv;
    if (q[m_sel].size() > 0) destino = q[m_sel][0][9:8];
    else                     destino = 2'($urandom);
    any       = (emp != 4'hf);
    was_empty = emp[m_sel];
    moving    = (m_phase == 2) && en_drv && !was_empty && !daf_drv[destino];
    e_pop     = moving ? 4'(1 << m_sel)   : 4'b0;
    e_push    = moving ? 4'(1 << destino) : 4'b0;

    @(negedge clk);
    check("pop", int'(pop), int'(e_pop));
    check("push", int'(push), int'(e_push));
    check("demux", int'(demux), m_sel);
    check("active", int'(active), int'(m_phase == 2));
    if (pop != 4'b0) begin
      pop_log.push_back($clog2(pop));
      pop_cyc.push_back(cyc);
    end
    if (push[1]) push1_cnt++;

    @(posedge clk);
    case (m_phase)
      0: if (en_drv && any) m_phase = 1;
      1: begin
        if (en_drv && any) begin
          pick = m_last;
          for (int k = 4; k >= 1; k--)
            if (q[(m_last + k) % 4].size() > 0) pick = (m_last + k) % 4;
          m_sel   = pick;
          m_last  = pick;
          m_moved = 0;
          m_phase = 2;
        end else begin
          m_phase = 0;
        end
      end
      default: begin
        if (moving) begin
          m_moved++;
          void'(q[m_sel].pop_front());
        end
        if (!en_drv) m_phase = 0;
        else if (was_empty || (moving && m_moved == BURST)) m_phase = any ? 1 : 0;
      end
    endcase
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_pops(input int n, input int budget);
    for (int i = 0; i < budget && pop_log.size() < n; i++) cycle();
    check("pops_within_budget", pop_log.size(), n);
  endtask

  task automatic do_reset();
    en_drv           = 1'b0;
    daf_drv          = 4'b0;
    enable           = 1'b0;
    fifo_empty       = 4'hf;
    destino          = 2'b0;
    dest_almost_full = 4'b0;
    reset            = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) q[i].delete();
    pop_log.delete();
    pop_cyc.delete();
    push1_cnt = 0;
    @(negedge clk);
    check("rst_pop", int'(pop), 0);
    check("rst_push", int'(push), 0);
    check("rst_demux", int'(demux), 0);
    check("rst_active", int'(active), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int f, input int n, input int dst);
    for (int i = 0; i < n; i++) q[f].push_back({2'(dst), 8'($urandom)});
  endtask

  // ---------------- back-pressure vector table ----------------
  typedef struct {
    logic       en;
    logic [3:0] emp;
    logic [1:0] dst;
    logic [3:0] daf;
    logic [3:0] e_pop;
    logic [3:0] e_push;
    logic [1:0] e_demux;
    logic       e_active;
  } vec_t;

  function automatic vec_t mkv(logic [3:0] daf, logic [3:0] p, logic [3:0] s,
                               logic [1:0] d, logic a);
    vec_t v;
    v.en = 1'b1; v.emp = 4'b1101; v.dst = 2'd3; v.daf = daf;
    v.e_pop = p; v.e_push = s; v.e_demux = d; v.e_active = a;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // FIFO1 alone requesting, head word bound for destination 3, which is
    // almost-full for 5 cycles after the first word moves.
    tbl[0]  = mkv(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);  // IDLE
    tbl[1]  = mkv(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);  // ARB
    tbl[2]  = mkv(4'b0000, 4'b0010, 4'b1000, 2'd1, 1'b1);  // word 1
    for (int i = 3; i <= 7; i++)
      tbl[i] = mkv(4'b1000, 4'b0000, 4'b0000, 2'd1, 1'b1);  // stalled
    tbl[8]  = mkv(4'b0000, 4'b0010, 4'b1000, 2'd1, 1'b1);  // word 2
    tbl[9]  = mkv(4'b0000, 4'b0010, 4'b1000, 2'd1, 1'b1);  // word 3
    tbl[10] = mkv(4'b0000, 4'b0010, 4'b1000, 2'd1, 1'b1);  // word 4
    tbl[11] = mkv(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);  // ARB bubble
    tbl[12] = mkv(4'b0000, 4'b0010, 4'b1000, 2'd1, 1'b1);  // re-won

    cyc = 0;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      enable           = tbl[i].en;
      fifo_empty       = tbl[i].emp;
      destino          = tbl[i].dst;
      dest_almost_full = tbl[i].daf;
      @(negedge clk);
      check($sformatf("bp%0d_pop", i), int'(pop), int'(tbl[i].e_pop));
      check($sformatf("bp%0d_push", i), int'(push), int'(tbl[i].e_push));
      check($sformatf("bp%0d_demux", i), int'(demux), int'(tbl[i].e_demux));
      check($sformatf("bp%0d_active", i), int'(active), int'(tbl[i].e_active));
      @(posedge clk);
      #1;
    end

    // Reset mid-burst: pop/push/demux/active drop immediately.
    do_reset();
    fill(0, 3, 0);
    en_drv = 1'b1;
    run_until_pops(1, 20);
    fifo_empty = 4'b1110;
    destino    = 2'd0;
    enable     = 1'b1;
    #2;
    check("midburst_pop_before_reset", int'(pop), 1);
    reset = 1'b0;
    #1;
    check("midreset_pop", int'(pop), 0);
    check("midreset_push", int'(push), 0);
    check("midreset_demux", int'(demux), 0);
    check("midreset_active", int'(active), 0);

    // Single requester: 4 words, one ARB bubble, 2 more words.
    do_reset();
    fill(2, 6, 1);
    en_drv = 1'b1;
    run_until_pops(6, 40);
    for (int i = 0; i < pop_log.size(); i++) check("single_src", pop_log[i], 2);
    check("single_push1_cnt", push1_cnt, 6);
    if (pop_cyc.size() == 6) begin
      check("single_burst_len", pop_cyc[3] - pop_cyc[0], 3);
      check("single_bubble", pop_cyc[4] - pop_cyc[3], 2);
    end
    run(4);
    check("single_idle_active", int'(active), 0);

    // All four requesting: grant order 0,1,2,3,0 with bursts of 4.
    do_reset();
    for (int f = 0; f < 4; f++) fill(f, 8, f);
    en_drv = 1'b1;
    run_until_pops(20, 80);
    for (int i = 0; i < pop_log.size(); i++)
      check($sformatf("rot_order%0d", i), pop_log[i], (i / 4) % 4);

    // Source drains: two words from 0, re-arbitrate, one from 3, idle.
    do_reset();
    fill(0, 2, 1);
    fill(3, 1, 2);
    en_drv = 1'b1;
    run_until_pops(3, 30);
    if (pop_log.size() == 3) begin
      check("drain_src0", pop_log[0], 0);
      check("drain_src1", pop_log[1], 0);
      check("drain_src2", pop_log[2], 3);
      check("drain_gap", pop_cyc[2] - pop_cyc[1], 3);
    end
    run(4);
    check("drain_total", pop_log.size(), 3);
    check("drain_active", int'(active), 0);

    // Enable drop mid-burst, then resume after the previous grant.
    do_reset();
    fill(1, 6, 0);
    fill(2, 3, 2);
    en_drv = 1'b1;
    run_until_pops(1, 20);
    check("en_first_src", pop_log[0], 1);
    en_drv = 1'b0;
    cycle();
    check("en_drop_no_pop", pop_log.size(), 1);
    check("en_drop_idle", int'(active), 0);
    cycle();
    en_drv = 1'b1;
    run_until_pops(2, 20);
    if (pop_log.size() == 2) check("en_resume_src", pop_log[1], 2);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int f;
        f = $urandom_range(0, 3);
        if (q[f].size() < 8) q[f].push_back(10'($urandom));
      end
      daf_drv = 4'($urandom & $urandom);
      en_drv  = ($urandom_range(0, 9) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
